// File: rtl/m_hart_mem_arbiter_if.sv
// Backing-memory command/response port shared by the two-hart DRAM arbiter.
// The arbiter drives the command side (master); the DRAM controller answers (slave).
interface m_hart_mem_arbiter_if;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [3:0]  w_mem_be;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_mem_rdata;
    logic        w_mem_ack;

    // Handshake: w_mem_req is a one-cycle strobe; we/addr/be/wdata are held
    // stable from the strobe until w_mem_ack, which completes the command and
    // qualifies w_mem_rdata. Only one command is ever outstanding.
    modport master (
        output w_mem_req, w_mem_we, w_mem_addr, w_mem_be, w_mem_wdata,
        input  w_mem_rdata, w_mem_ack
    );

    modport slave (
        input  w_mem_req, w_mem_we, w_mem_addr, w_mem_be, w_mem_wdata,
        output w_mem_rdata, w_mem_ack
    );
endinterface

// File: rtl/m_hart_mem_arbiter.sv
// Two-hart DRAM request arbiter: per-hart pending capture, IDLE/REQ/WAIT FSM,
// byte-lane steering and load extension. Define ARB_ROUND_ROBIN_EN for round-robin.
module m_hart_mem_arbiter (
    input  logic                        CLK,
    input  logic                        RST_X,
    input  logic [31:0]                 w_h0_addr,
    input  logic [31:0]                 w_h1_addr,
    input  logic [31:0]                 w_h0_wdata,
    input  logic [31:0]                 w_h1_wdata,
    input  logic                        w_h0_we,
    input  logic                        w_h1_we,
    input  logic                        w_h0_le,
    input  logic                        w_h1_le,
    input  logic [2:0]                  w_h0_ctrl,
    input  logic [2:0]                  w_h1_ctrl,
    output logic                        w_h0_busy,
    output logic                        w_h1_busy,
    output logic [31:0]                 w_h0_odata,
    output logic [31:0]                 w_h1_odata,
    output logic [31:0]                 w_grant,
    output logic [1:0]                  w_dbg_state,
    m_hart_mem_arbiter_if.master        mem
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    state_t           state;
    logic             owner;
    logic             sel;
    logic [1:0]       pend;
    logic [1:0]       pend_we;
    logic [1:0][31:0] pend_addr;
    logic [1:0][31:0] pend_wdata;
    logic [1:0][2:0]  pend_ctrl;
    logic [1:0][31:0] odata;
    logic [1:0][31:0] in_addr;
    logic [1:0][31:0] in_wdata;
    logic [1:0][2:0]  in_ctrl;
    logic [1:0]       in_we;
    logic [1:0]       in_le;
    logic [31:0]      ld_data;

    assign in_addr  = {w_h1_addr, w_h0_addr};
    assign in_wdata = {w_h1_wdata, w_h0_wdata};
    assign in_ctrl  = {w_h1_ctrl, w_h0_ctrl};
    assign in_we    = {w_h1_we, w_h0_we};
    assign in_le    = {w_h1_le, w_h0_le};

    assign w_h0_busy   = pend[0];
    assign w_h1_busy   = pend[1];
    assign w_h0_odata  = odata[0];
    assign w_h1_odata  = odata[1];
    assign w_grant     = {31'b0, owner};
    assign w_dbg_state = state;

    function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] a);
        case (ctrl)
            3'b000:  lane_be = 4'b0001 << a;
            3'b001:  lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] ctrl, input logic [31:0] w);
        case (ctrl)
            3'b000:  lane_wdata = {4{w[7:0]}};
            3'b001:  lane_wdata = {2{w[15:0]}};
            default: lane_wdata = w;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] ctrl, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] hw;
        b  = 8'(rdata >> {a, 3'b000});
        hw = a[1] ? rdata[31:16] : rdata[15:0];
        case (ctrl)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b001:  format_load = {{16{hw[15]}}, hw};
            3'b100:  format_load = {24'b0, b};
            3'b101:  format_load = {16'b0, hw};
            default: format_load = rdata;
        endcase
    endfunction

    // A lone pending hart always wins; the macro only changes the tie-break.
`ifdef ARB_ROUND_ROBIN_EN
    assign sel = (&pend) ? ~owner : ~pend[0];
`else
    assign sel = ~pend[0];
`endif

    assign ld_data = format_load(pend_ctrl[owner], pend_addr[owner][1:0], mem.w_mem_rdata);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state           <= S_IDLE;
            owner           <= 1'b0;
            pend            <= '0;
            pend_we         <= '0;
            pend_addr       <= '0;
            pend_wdata      <= '0;
            pend_ctrl       <= '0;
            odata           <= '0;
            mem.w_mem_req   <= 1'b0;
            mem.w_mem_we    <= 1'b0;
            mem.w_mem_addr  <= '0;
            mem.w_mem_be    <= '0;
            mem.w_mem_wdata <= '0;
        end else begin
            // Capture only while idle; a pulse while busy is dropped.
            for (int h = 0; h < 2; h++) begin
                if (!pend[h] && (in_we[h] || in_le[h])) begin
                    pend[h]       <= 1'b1;
                    pend_we[h]    <= in_we[h];
                    pend_addr[h]  <= in_addr[h];
                    pend_wdata[h] <= in_wdata[h];
                    pend_ctrl[h]  <= in_ctrl[h];
                end
            end

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        owner           <= sel;
                        state           <= S_REQ;
                        mem.w_mem_req   <= 1'b1;
                        mem.w_mem_we    <= pend_we[sel];
                        mem.w_mem_addr  <= {pend_addr[sel][31:2], 2'b00};
                        mem.w_mem_be    <= pend_we[sel] ? lane_be(pend_ctrl[sel], pend_addr[sel][1:0])
                                                        : 4'b1111;
                        mem.w_mem_wdata <= lane_wdata(pend_ctrl[sel], pend_wdata[sel]);
                    end
                end
                S_REQ: begin
                    mem.w_mem_req <= 1'b0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem.w_mem_ack) begin
                        if (!pend_we[owner]) begin
                            odata[owner] <= ld_data;
                        end
                        pend[owner] <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
